// File: rtl/id_ex_reg_pkg.sv
// Shared pipeline widths and field-group types used by the hazard mux, ID/EX and EX/MEM registers.
// Control and data are grouped as packed structs so each group moves through one pipe_reg.
package id_ex_reg_pkg;

    localparam int ALU_OP_W     = 2;
    localparam int MEM_CTRL_W   = 3;
    localparam int WB_CTRL_W    = 2;
    localparam int REG_ADDR_W   = 5;
    localparam int DATA_W       = 32;
    localparam int BUBBLE_CNT_W = 16;

    typedef struct packed {
        logic                  reg_dest;
        logic [ALU_OP_W-1:0]   alu_op;
        logic                  alu_src;
        logic [MEM_CTRL_W-1:0] mem_ctrl;
        logic [WB_CTRL_W-1:0]  wb_ctrl;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_W-1:0]     pc_plus4;
        logic [DATA_W-1:0]     read_data1;
        logic [DATA_W-1:0]     read_data2;
        logic [DATA_W-1:0]     sign_ext_imm;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
    } data_t;

    localparam int CTRL_W     = $bits(ctrl_t);
    localparam int DATA_BUS_W = $bits(data_t);

    // The hazard mux signals a bubble by zeroing every control field.
    function automatic logic is_ctrl_bubble(input ctrl_t c);
        return (c == '0);
    endfunction

    function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] c);
        return (c == '1) ? c : c + {{(BUBBLE_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/id_ex_reg_pipe_reg.sv
// Generic pipeline register slice: sync reset and clear load zero, enable=0 holds.
// One cycle latency; clear takes priority over enable so a flush wins over a stall.
module pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= '0;
        end else if (clear) begin
            q_q <= '0;
        end else if (enable) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: 1-cycle latency, stall holds every field, flush inserts a zeroed bubble.
// Also counts bubbles entering EX (saturating), excluding reset cycles.
import id_ex_reg_pkg::*;

module id_ex_reg (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    validIn,
    input  logic                    hzdRegDest,
    input  logic [ALU_OP_W-1:0]     hzdAluOp,
    input  logic                    hzdAluSrc,
    input  logic [MEM_CTRL_W-1:0]   hzdMemControlIdEx,
    input  logic [WB_CTRL_W-1:0]    hzdWbControlIdEx,
    input  logic [DATA_W-1:0]       pcPlus4,
    input  logic [DATA_W-1:0]       readData1,
    input  logic [DATA_W-1:0]       readData2,
    input  logic [DATA_W-1:0]       signExtImm,
    input  logic [REG_ADDR_W-1:0]   rs,
    input  logic [REG_ADDR_W-1:0]   rt,
    input  logic [REG_ADDR_W-1:0]   rd,
    output logic                    exRegDest,
    output logic [ALU_OP_W-1:0]     exAluOp,
    output logic                    exAluSrc,
    output logic [MEM_CTRL_W-1:0]   memControlIdEx,
    output logic [WB_CTRL_W-1:0]    wbControlIdEx,
    output logic [DATA_W-1:0]       exPcPlus4,
    output logic [DATA_W-1:0]       exReadData1,
    output logic [DATA_W-1:0]       exReadData2,
    output logic [DATA_W-1:0]       exSignExtImm,
    output logic [REG_ADDR_W-1:0]   exRs,
    output logic [REG_ADDR_W-1:0]   exRt,
    output logic [REG_ADDR_W-1:0]   exRd,
    output logic                    validOut,
    output logic [BUBBLE_CNT_W-1:0] bubbleCount
);

    ctrl_t ctrl_in;
    ctrl_t ctrl_q;
    data_t data_in;
    data_t data_q;
    logic  valid_in_d;
    logic  valid_q;
    logic  load_en;
    logic  bubble;

    logic [BUBBLE_CNT_W-1:0] bubble_cnt_d;
    logic [BUBBLE_CNT_W-1:0] bubble_cnt_q;

    assign ctrl_in = {hzdRegDest, hzdAluOp, hzdAluSrc, hzdMemControlIdEx, hzdWbControlIdEx};
    assign data_in = {pcPlus4, readData1, readData2, signExtImm, rs, rt, rd};

    assign load_en = ~stall;

    // A zeroed control word from the hazard mux is not a real instruction even if ID says valid.
    assign valid_in_d = validIn & ~is_ctrl_bubble(ctrl_in);

    pipe_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
        .clock  (clock),
        .reset  (reset),
        .enable (load_en),
        .clear  (flush),
        .d      (ctrl_in),
        .q      (ctrl_q)
    );

    pipe_reg #(.WIDTH(DATA_BUS_W)) u_data_reg (
        .clock  (clock),
        .reset  (reset),
        .enable (load_en),
        .clear  (flush),
        .d      (data_in),
        .q      (data_q)
    );

    pipe_reg #(.WIDTH(1)) u_valid_reg (
        .clock  (clock),
        .reset  (reset),
        .enable (load_en),
        .clear  (flush),
        .d      (valid_in_d),
        .q      (valid_q)
    );

    // Flush counts once even when stall is also high; a plain stall never counts.
    assign bubble = flush | (load_en & (~validIn | is_ctrl_bubble(ctrl_in)));

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble) begin
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign exRegDest      = ctrl_q.reg_dest;
    assign exAluOp        = ctrl_q.alu_op;
    assign exAluSrc       = ctrl_q.alu_src;
    assign memControlIdEx = ctrl_q.mem_ctrl;
    assign wbControlIdEx  = ctrl_q.wb_ctrl;

    assign exPcPlus4      = data_q.pc_plus4;
    assign exReadData1    = data_q.read_data1;
    assign exReadData2    = data_q.read_data2;
    assign exSignExtImm   = data_q.sign_ext_imm;
    assign exRs           = data_q.rs;
    assign exRt           = data_q.rt;
    assign exRd           = data_q.rd;

    assign validOut       = valid_q;
    assign bubbleCount    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed-vector bench for id_ex_reg with a queue scoreboard checked by an independent monitor.
module tb_id_ex_reg;

    typedef struct packed {
        logic        rst, stl, fls, vld;
        logic [8:0]  ctrl;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  rs, rt, rd;
    } in_t;

    typedef struct packed {
        logic [8:0]  ctrl;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  rs, rt, rd;
        logic        vld;
        logic [15:0] bc;
    } out_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0, stall = 1'b0, flush = 1'b0, validIn = 1'b0;
    logic        hzdRegDest = 1'b0, hzdAluSrc = 1'b0;
    logic [1:0]  hzdAluOp = '0, hzdWbControlIdEx = '0;
    logic [2:0]  hzdMemControlIdEx = '0;
    logic [31:0] pcPlus4 = '0, readData1 = '0, readData2 = '0, signExtImm = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;

    logic        exRegDest, exAluSrc, validOut;
    logic [1:0]  exAluOp, wbControlIdEx;
    logic [2:0]  memControlIdEx;
    logic [31:0] exPcPlus4, exReadData1, exReadData2, exSignExtImm;
    logic [4:0]  exRs, exRt, exRd;
    logic [15:0] bubbleCount;

    int   total = 0;
    int   bad   = 0;
    out_t exp_q[$];

    always #5 clock = ~clock;

    id_ex_reg dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush), .validIn(validIn),
        .hzdRegDest(hzdRegDest), .hzdAluOp(hzdAluOp), .hzdAluSrc(hzdAluSrc),
        .hzdMemControlIdEx(hzdMemControlIdEx), .hzdWbControlIdEx(hzdWbControlIdEx),
        .pcPlus4(pcPlus4), .readData1(readData1), .readData2(readData2), .signExtImm(signExtImm),
        .rs(rs), .rt(rt), .rd(rd),
        .exRegDest(exRegDest), .exAluOp(exAluOp), .exAluSrc(exAluSrc),
        .memControlIdEx(memControlIdEx), .wbControlIdEx(wbControlIdEx),
        .exPcPlus4(exPcPlus4), .exReadData1(exReadData1), .exReadData2(exReadData2),
        .exSignExtImm(exSignExtImm), .exRs(exRs), .exRt(exRt), .exRd(exRd),
        .validOut(validOut), .bubbleCount(bubbleCount)
    );

    function automatic in_t mk_in(input logic r, input logic s, input logic f, input logic v,
                                  input logic [8:0] c, input logic [31:0] pc, input logic [31:0] r1,
                                  input logic [31:0] r2, input logic [31:0] imm,
                                  input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        in_t x;
        x.rst = r; x.stl = s; x.fls = f; x.vld = v; x.ctrl = c;
        x.pc = pc; x.r1 = r1; x.r2 = r2; x.imm = imm; x.rs = a; x.rt = b; x.rd = d;
        return x;
    endfunction

    function automatic out_t mk_out(input logic [8:0] c, input logic [31:0] pc, input logic [31:0] r1,
                                    input logic [31:0] r2, input logic [31:0] imm,
                                    input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                                    input logic v, input logic [15:0] bc);
        out_t x;
        x.ctrl = c; x.pc = pc; x.r1 = r1; x.r2 = r2; x.imm = imm;
        x.rs = a; x.rt = b; x.rd = d; x.vld = v; x.bc = bc;
        return x;
    endfunction

    function automatic out_t zero_out(input logic [15:0] bc);
        return mk_out(9'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, bc);
    endfunction

    // Drive one vector just after the falling edge; its expected result is due at the next falling edge.
    task automatic step(input in_t i, input out_t e);
        @(negedge clock);
        #1;
        reset = i.rst; stall = i.stl; flush = i.fls; validIn = i.vld;
        {hzdRegDest, hzdAluOp, hzdAluSrc, hzdMemControlIdEx, hzdWbControlIdEx} = i.ctrl;
        pcPlus4 = i.pc; readData1 = i.r1; readData2 = i.r2; signExtImm = i.imm;
        rs = i.rs; rt = i.rt; rd = i.rd;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            out_t e;
            e = exp_q.pop_front();
            chk("ctrl", 32'({exRegDest, exAluOp, exAluSrc, memControlIdEx, wbControlIdEx}), 32'(e.ctrl));
            chk("pcPlus4", exPcPlus4, e.pc);
            chk("readData1", exReadData1, e.r1);
            chk("readData2", exReadData2, e.r2);
            chk("signExtImm", exSignExtImm, e.imm);
            chk("regs", 32'({exRs, exRt, exRd}), 32'({e.rs, e.rt, e.rd}));
            chk("validOut", 32'(validOut), 32'(e.vld));
            chk("bubbleCount", 32'(bubbleCount), 32'(e.bc));
        end
    end

    localparam logic [8:0] C_LOAD = 9'b0_10_0_000_11;
    localparam logic [8:0] C_B    = 9'b1_01_1_010_10;

    initial begin
        in_t  vi;
        out_t held;

        // Reset with every input nonzero, then a quiet reset cycle.
        step(mk_in(1, 1, 1, 1, 9'h1FF, 32'hFFFF_FFFF, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                   5'd31, 5'd30, 5'd29), zero_out(16'd0));
        step(mk_in(1, 0, 0, 0, 9'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0), zero_out(16'd0));

        // Normal load.
        step(mk_in(0, 0, 0, 1, C_LOAD, 32'h100, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFF0, 5'd1, 5'd2, 5'd9),
             mk_out(C_LOAD, 32'h100, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFF0, 5'd1, 5'd2, 5'd9, 1'b1, 16'd0));

        // Load readData2 then stall three cycles with changed inputs.
        held = mk_out(C_B, 32'h104, 32'h0, 32'h1234_5678, 32'h4, 5'd3, 5'd4, 5'd5, 1'b1, 16'd0);
        step(mk_in(0, 0, 0, 1, C_B, 32'h104, 32'h0, 32'h1234_5678, 32'h4, 5'd3, 5'd4, 5'd5), held);
        for (int k = 0; k < 3; k++)
            step(mk_in(0, 1, 0, 0, 9'h0, 32'h999, 32'h5, 32'h0, 32'h7, 5'd7, 5'd8, 5'd10), held);

        // Stall and flush together with live control: one bubble.
        step(mk_in(0, 1, 1, 1, C_B, 32'h108, 32'h9, 32'hA, 32'hB, 5'd11, 5'd12, 5'd13), zero_out(16'd1));

        // Hazard-mux bubbles: data still captured, validOut low, count +1 each.
        for (int k = 0; k < 4; k++)
            step(mk_in(0, 0, 0, 1, 9'h0, 32'h200 + 32'(k), 32'hAAAA_5555, 32'h5555_AAAA, 32'h10, 5'd14, 5'd15, 5'd16),
                 mk_out(9'h0, 32'h200 + 32'(k), 32'hAAAA_5555, 32'h5555_AAAA, 32'h10, 5'd14, 5'd15, 5'd16,
                        1'b0, 16'(2 + k)));

        // validIn low with live control is a bubble but control still loads.
        step(mk_in(0, 0, 0, 0, C_LOAD, 32'h300, 32'h1, 32'h2, 32'h3, 5'd17, 5'd18, 5'd19),
             mk_out(C_LOAD, 32'h300, 32'h1, 32'h2, 32'h3, 5'd17, 5'd18, 5'd19, 1'b0, 16'd6));

        // Flush alone.
        step(mk_in(0, 0, 1, 1, C_B, 32'h304, 32'h4, 32'h5, 32'h6, 5'd20, 5'd21, 5'd22), zero_out(16'd7));

        // Reset during a stall overrides it; the following stall then holds the zeros.
        step(mk_in(1, 1, 0, 1, C_B, 32'h400, 32'h4, 32'h5, 32'h6, 5'd1, 5'd1, 5'd1), zero_out(16'd0));
        step(mk_in(0, 1, 0, 1, C_B, 32'h404, 32'h4, 32'h5, 32'h6, 5'd1, 5'd1, 5'd1), zero_out(16'd0));
        step(mk_in(0, 0, 0, 1, C_B, 32'h408, 32'h4, 32'h5, 32'h6, 5'd2, 5'd3, 5'd4),
             mk_out(C_B, 32'h408, 32'h4, 32'h5, 32'h6, 5'd2, 5'd3, 5'd4, 1'b1, 16'd0));

        // Saturation: 65540 consecutive flush bubbles starting from a count of zero.
        step(mk_in(1, 0, 0, 0, 9'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0), zero_out(16'd0));
        vi = mk_in(0, 0, 1, 1, C_B, 32'h500, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3);
        for (int k = 1; k <= 65540; k++)
            step(vi, zero_out((k > 65535) ? 16'hFFFF : 16'(k)));

        // Reset mid-flush clears the count; the next flush counts from zero again.
        step(mk_in(1, 0, 1, 1, C_B, 32'h500, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3), zero_out(16'd0));
        step(vi, zero_out(16'd1));

        @(negedge clock);
        @(negedge clock);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have ports: clock  in  1  rising-edge clock for all state.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high; sampled only on clock rising edge.
REQ-003 SHALL have ports: stall  in  1  hold all registers (load-use stall from hazard unit).
REQ-004 SHALL have ports: flush  in  1  load a bubble (branch taken / exception).
REQ-005 SHALL have ports: validIn  in  1  ID stage holds a real instruction.
REQ-006 SHALL have ports: hzdRegDest in 1; hzdAluOp in 2; hzdAluSrc in 1; hzdMemControlIdEx in 3; hzdWbControlIdEx in 2 -- post-hazard-mux control fields.
REQ-007 SHALL have ports: pcPlus4 in 32; readData1 in 32; readData2 in 32; signExtImm in 32; rs in 5; rt in 5; rd in 5.
REQ-008 SHALL have ports: exRegDest out 1; exAluOp out 2; exAluSrc out 1; memControlIdEx out 3; wbControlIdEx out 2 -- registered control.
REQ-009 SHALL have ports: exPcPlus4, exReadData1, exReadData2, exSignExtImm out 32 each; exRs, exRt, exRd out 5 each.
REQ-010 SHALL have ports: validOut  out  1  EX stage holds a real instruction.
REQ-011 SHALL have ports: bubbleCount  out  16  number of bubbles entered into EX since reset.

Function
REQ-012 SHALL be a single pipeline stage: outputs reflect inputs sampled at the previous rising edge; latency exactly 1 cycle.
REQ-013 SHALL apply per-edge priority: reset > flush > stall > normal load.
REQ-014 Normal load (stall=0, flush=0): all control, data, and validOut SHALL capture inputs.
REQ-015 Stall (stall=1, flush=0): every output, validOut and bubbleCount SHALL hold their current value.
REQ-016 Flush (flush=1): all control outputs SHALL be 0, all data outputs SHALL be 0, and validOut SHALL be 0, regardless of stall.
REQ-017 A cycle is a bubble when flush=1, or when a normal load occurs with validIn=0 or with all five control inputs zero.
REQ-018 bubbleCount SHALL increment by 1 on each bubble cycle and saturate at 16'hFFFF (no wrap).
REQ-019 On normal load with validIn=1 but all control inputs zero (hazard-mux bubble), validOut SHALL be 0.
REQ-020 Stall and flush asserted together SHALL behave as flush (bubble counted once).
REQ-021 Data fields SHALL be passed unmodified; no arithmetic other than the bubbleCount increment.

Reset
REQ-022 On reset=1 at a rising edge, all control outputs, all data outputs, validOut and bubbleCount SHALL become 0.
REQ-023 Reset asserted mid-stall or mid-flush SHALL override both; the first edge after reset deasserts performs a normal load/stall/flush per REQ-013.
REQ-024 The reset cycle SHALL NOT be counted as a bubble.

Structure
REQ-025 Widths (ALU_OP_W=2, MEM_CTRL_W=3, WB_CTRL_W=2, REG_ADDR_W=5, DATA_W=32, BUBBLE_CNT_W=16) SHALL live in the shared pipeline package, reused by the hazard mux and the EX/MEM register.
REQ-026 One sub-module pipe_reg (parameter WIDTH; inputs clock, reset, enable, clear, d; output q; clear loads 0, enable=0 holds) SHALL be instantiated once per field group (control, data, valid).
REQ-027 The bubble counter SHALL be local logic in id_ex_reg, not in pipe_reg.

Verification
REQ-028 Reset: drive reset=1 one edge with all inputs nonzero -> all outputs 0, bubbleCount=0.
REQ-029 Normal load: validIn=1, hzdAluOp=2'b10, hzdWbControlIdEx=2'b11, readData1=32'hDEADBEEF, rd=5'd9 -> next cycle exAluOp=2'b10, wbControlIdEx=2'b11, exReadData1=32'hDEADBEEF, exRd=9, validOut=1, bubbleCount unchanged.
REQ-030 Stall: load readData2=32'h12345678, then stall=1 for 3 cycles with readData2=32'h0 -> exReadData2 stays 32'h12345678 for all 3 cycles; bubbleCount unchanged.
REQ-031 Flush with stall: stall=1, flush=1 together, control inputs nonzero -> next cycle all outputs 0, validOut=0, bubbleCount increments by exactly 1.
REQ-032 Hazard bubble: validIn=1, all control inputs 0 for 4 cycles -> validOut=0 each cycle, bubbleCount +4.
REQ-033 Saturation: force 65 540 consecutive bubbles -> bubbleCount reaches 16'hFFFF and stays; then reset mid-sequence -> 0 next edge.
